// File: rtl/uart_tx_if.sv
// Interface carrying the UART transmitter parameters and data-path signals.
// The tx modport is the transmitter's view of the link.
interface uart_tx_if #(
    parameter int width      = 8,
    parameter int baud_rate  = 9600,
    parameter int clock_freq = 460800
);
    logic             can_send_next_word;
    logic [width-1:0] data;
    logic             signal;
    logic             ready;

    modport tx (
        input  can_send_next_word,
        input  data,
        output signal,
        output ready
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional even parity, one stop bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx (
    input logic   clock,
    input logic   reset,
    uart_tx_if.tx tx_if
);
    localparam int WIDTH = tx_if.width;
    localparam int TICKS = tx_if.clock_freq / tx_if.baud_rate;
    localparam int CW    = $clog2(TICKS);
    localparam int BW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state_reg, state_next;
    logic [CW-1:0]    tick_reg, tick_next;
    logic [BW-1:0]    bit_reg, bit_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic             signal_reg, signal_next;
    logic             ready_reg, ready_next;
    logic             accept;
    logic             tick_last;
    logic             bit_last;
`ifdef UART_TX_PARITY_EN
    logic             parity_reg, parity_next;
`endif

    assign tick_last    = (tick_reg == CW'(TICKS - 1));
    assign bit_last     = (bit_reg == BW'(WIDTH - 1));
    assign tx_if.signal = signal_reg;
    assign tx_if.ready  = ready_reg;

    // Outputs are computed from the next state so the line is driven straight from flops.
    always_comb begin
        state_next  = state_reg;
        tick_next   = tick_reg;
        bit_next    = bit_reg;
        shift_next  = shift_reg;
        signal_next = signal_reg;
        ready_next  = ready_reg;
        accept      = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next = parity_reg;
`endif
        case (state_reg)
            IDLE: begin
                signal_next = 1'b1;
                ready_next  = 1'b1;
                accept      = tx_if.can_send_next_word;
            end
            START: begin
                if (tick_last) begin
                    tick_next   = '0;
                    state_next  = DATA;
                    signal_next = shift_reg[0];
                end else begin
                    tick_next = tick_reg + CW'(1);
                end
            end
            DATA: begin
                if (tick_last) begin
                    tick_next = '0;
                    if (bit_last) begin
                        bit_next = '0;
`ifdef UART_TX_PARITY_EN
                        state_next  = PARITY;
                        signal_next = parity_reg;
`else
                        state_next  = STOP;
                        signal_next = 1'b1;
                        ready_next  = 1'b1;
`endif
                    end else begin
                        bit_next    = bit_reg + BW'(1);
                        shift_next  = shift_reg >> 1;
                        signal_next = shift_next[0];
                    end
                end else begin
                    tick_next = tick_reg + CW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick_last) begin
                    tick_next   = '0;
                    state_next  = STOP;
                    signal_next = 1'b1;
                    ready_next  = 1'b1;
                end else begin
                    tick_next = tick_reg + CW'(1);
                end
            end
`endif
            STOP: begin
                if (tick_last) begin
                    tick_next  = '0;
                    state_next = IDLE;
                    accept     = tx_if.can_send_next_word;
                end else begin
                    tick_next = tick_reg + CW'(1);
                end
            end
            default: begin
                state_next  = IDLE;
                tick_next   = '0;
                bit_next    = '0;
                signal_next = 1'b1;
                ready_next  = 1'b1;
            end
        endcase

        // A request can only land in IDLE or on the last stop-bit cycle.
        if (accept) begin
            state_next  = START;
            tick_next   = '0;
            bit_next    = '0;
            shift_next  = tx_if.data;
            signal_next = 1'b0;
            ready_next  = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_next = ^tx_if.data;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= IDLE;
            tick_reg   <= '0;
            bit_reg    <= '0;
            shift_reg  <= '0;
            signal_reg <= 1'b1;
            ready_reg  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            tick_reg   <= tick_next;
            bit_reg    <= bit_next;
            shift_reg  <= shift_next;
            signal_reg <= signal_next;
            ready_reg  <= ready_next;
`ifdef UART_TX_PARITY_EN
            parity_reg <= parity_next;
`endif
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed frame table, back-to-back, reset abort
// and a randomized data sweep checked cycle by cycle against a bit-period model.
module tb_uart_tx;
    localparam int TICKS = 460800 / 9600;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FL = NBITS * TICKS;

    typedef struct {
        logic [7:0] data;
        logic       exp_par;
        logic [9:0] exp_line;  // {stop, d7..d0, start}
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int errors = 0;
    int checks = 0;
    logic [10:0] last_cap;
    vec_t vecs[9];

    uart_tx_if #(.width(8), .baud_rate(9600), .clock_freq(460800)) tx_if ();

    uart_tx dut (
        .clock (clock),
        .reset (reset),
        .tx_if (tx_if)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected line level k cycles after the acceptance edge.
    function automatic logic exp_sig(input logic [7:0] d, input int k);
        int p;
        p = k / TICKS;
        if (p == 0) return 1'b0;
        if (p <= 8) return d[p-1];
`ifdef UART_TX_PARITY_EN
        if (p == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    function automatic logic exp_rdy(input int k);
        return (k / TICKS) == (NBITS - 1);
    endfunction

    // Caller sets data/can_send before the acceptance edge; inputs are scrambled
    // during the frame and left to the caller on the final stop cycle.
    task automatic run_frame(input logic [7:0] d, input int ncyc, input string tag);
        int bad;
        int first_bad;
        logic [10:0] cap;
        bad = 0;
        first_bad = -1;
        cap = '0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clock);
            if (tx_if.signal !== exp_sig(d, k) || tx_if.ready !== exp_rdy(k)) begin
                bad++;
                if (first_bad < 0) first_bad = k;
            end
            if (k % TICKS == TICKS / 2) cap[k / TICKS] = tx_if.signal;
            if (k < FL - 1) begin
                tx_if.data = 8'($urandom);
                tx_if.can_send_next_word = 1'($urandom_range(0, 1));
            end
        end
        last_cap = cap;
        $display("frame %s data=%02h cycles=%0d bad_cycles=%0d first_bad=%0d bits=%b",
                 tag, d, ncyc, bad, first_bad, cap);
        chk({tag, "_frame"}, 32'(bad), 32'd0);
    endtask

    task automatic idle_cycles(input int n, input string tag);
        int bad;
        bad = 0;
        tx_if.can_send_next_word = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            if (tx_if.signal !== 1'b1 || tx_if.ready !== 1'b1) bad++;
        end
        $display("idle %s cycles=%0d bad_cycles=%0d", tag, n, bad);
        chk({tag, "_idle"}, 32'(bad), 32'd0);
    endtask

    task automatic start_req(input logic [7:0] d);
        tx_if.data = d;
        tx_if.can_send_next_word = 1'b1;
    endtask

    initial begin
        logic [10:0] exp;
        vecs[0] = '{8'h15, 1'b1, 10'b1_00010101_0};
        vecs[1] = '{8'h07, 1'b1, 10'b1_00000111_0};
        vecs[2] = '{8'h03, 1'b0, 10'b1_00000011_0};
        vecs[3] = '{8'hA5, 1'b0, 10'b1_10100101_0};
        vecs[4] = '{8'h3C, 1'b0, 10'b1_00111100_0};
        vecs[5] = '{8'h00, 1'b0, 10'b1_00000000_0};
        vecs[6] = '{8'hFF, 1'b0, 10'b1_11111111_0};
        vecs[7] = '{8'h80, 1'b1, 10'b1_10000000_0};
        vecs[8] = '{8'h01, 1'b1, 10'b1_00000001_0};

        tx_if.can_send_next_word = 1'b0;
        tx_if.data = 8'h00;
        reset = 1'b1;
        @(negedge clock);
        chk("reset_state", 32'({tx_if.signal, tx_if.ready}), 32'b11);
        reset = 1'b0;
        idle_cycles(100, "post_reset");

        for (int i = 0; i < 9; i++) begin
            start_req(vecs[i].data);
            run_frame(vecs[i].data, FL, "table");
`ifdef UART_TX_PARITY_EN
            exp = {vecs[i].exp_line[9], vecs[i].exp_par, vecs[i].exp_line[8:0]};
`else
            exp = {1'b0, vecs[i].exp_line};
`endif
            chk("table_bits", 32'(last_cap), 32'(exp));
            idle_cycles(int'($urandom_range(2, 10)), "table_gap");
        end

        // Back-to-back: request held through the final stop cycle.
        start_req(8'hA5);
        run_frame(8'hA5, FL, "b2b_first");
        start_req(8'h3C);
        run_frame(8'h3C, FL, "b2b_second");
        idle_cycles(5, "b2b_gap");

        for (int n = 0; n < 6; n++) begin
            logic [7:0] d;
            d = 8'($urandom);
            start_req(d);
            run_frame(d, FL, "rand_chain");
        end
        idle_cycles(3, "chain_gap");

        // Abort during data bit 3, then the very next edge must accept.
        start_req(8'hFF);
        run_frame(8'hFF, 4 * TICKS + TICKS / 2, "abort_part");
        reset = 1'b1;
        tx_if.can_send_next_word = 1'b0;
        @(negedge clock);
        chk("abort_reset", 32'({tx_if.signal, tx_if.ready}), 32'b11);
        reset = 1'b0;
        start_req(8'h5A);
        run_frame(8'h5A, FL, "after_reset");
        idle_cycles(4, "after_reset_gap");

        for (int d = 21; d <= 255; d += 3) begin
            start_req(8'(d));
            run_frame(8'(d), FL, "sweep");
            idle_cycles(int'($urandom_range(24, 48)), "sweep_gap");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter width, default 8: data word width in bits.
REQ-002 Parameter baud_rate, default 9600: serial bit rate in bit/s.
REQ-003 Parameter clock_freq, default 460800: clock frequency in Hz; TICKS = clock_freq / baud_rate (integer division, 48 at defaults), SHALL be >= 2.
REQ-004 All parameters and data signals SHALL be carried by interface uart_tx_if; the module port tx_if SHALL be of that type.
REQ-005 clock  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  one clock; reset is synchronous and active-high.
REQ-007 tx_if.can_send_next_word  input  1  request to transmit tx_if.data.
REQ-008 tx_if.data  input  width  word to transmit, sampled only at acceptance.
REQ-009 tx_if.signal  output  1  serial line, idle high, registered.
REQ-010 tx_if.ready  output  1  high when a new request can be accepted, registered.

Function
REQ-011 FSM states SHALL be IDLE, START, DATA, STOP; a tick counter (0..TICKS-1) SHALL time each bit, and a bit index (0..width-1) SHALL track DATA.
REQ-012 IDLE: signal=1, ready=1; a rising edge with can_send_next_word=1 SHALL latch data into a shift register and enter START.
REQ-013 START: signal=0, ready=0 for exactly TICKS cycles, starting on the cycle after acceptance (latency 1 clock).
REQ-014 DATA: width bits, LSB first, each held exactly TICKS cycles, ready=0.
REQ-015 STOP: signal=1, ready=1 for exactly TICKS cycles.
REQ-016 can_send_next_word SHALL be ignored during START, DATA and all STOP cycles except the final one.
REQ-017 On the final STOP cycle edge: can_send_next_word=1 -> latch data, go to START (back-to-back frame, no idle gap); else -> IDLE.
REQ-018 Changes on tx_if.data after acceptance SHALL NOT affect the frame in progress.
REQ-019 Frame length without parity SHALL be (width+2)*TICKS cycles; signal SHALL be glitch-free (register output).

Reset
REQ-020 While reset=1 at a rising edge: state=IDLE, counters=0, shift register=0, signal=1, ready=1.
REQ-021 Reset asserted mid-frame SHALL abort the frame; line returns to 1 on the next edge, and no partial frame resumes.
REQ-022 First request SHALL be accepted on the first edge after reset deasserts.

Configuration
REQ-023 Macro UART_TX_PARITY_EN defined: one even-parity bit (XOR of the latched word) SHALL be sent for TICKS cycles between the last data bit and STOP, ready=0; frame = (width+3)*TICKS cycles.
REQ-024 Macro UART_TX_PARITY_EN undefined: no parity state or logic; frame per REQ-019.

Verification
REQ-025 Reset 1 cycle, release, hold can_send_next_word=0 for 100 cycles -> signal=1, ready=1 every cycle.
REQ-026 Send 0x15 at defaults -> 48 cycles signal=0/ready=0, bits 1,0,1,0,1,0,0,0 each 48 cycles with ready=0, then 48 cycles signal=1/ready=1.
REQ-027 Sweep data 21..255, keep can_send_next_word=1 through the stop bit, drop it, wait 24..48 random cycles -> every frame bit-exact per REQ-026, ready=1 one cycle after drop.
REQ-028 Keep can_send_next_word=1 continuously with 0xA5 then 0x3C -> second start bit begins on the cycle after the 48th stop cycle.
REQ-029 Assert reset during data bit 3 of 0xFF -> next cycle signal=1, ready=1; a new request sends a full correct frame.
REQ-030 With UART_TX_PARITY_EN, send 0x07 -> parity bit 1 after bit 7; send 0x03 -> parity bit 0; frame 528 cycles.
